// File: rtl/quark_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : quark_arb_pkg
//  Description : Shared types and helpers for the quark egress write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package quark_arb_pkg;

    // Upper bounds for the stored AW fields; instances narrow them on output.
    localparam int MAX_EID_W  = 16;
    localparam int MAX_ADDR_W = 64;

    typedef struct packed {
        logic [MAX_EID_W-1:0]  id;
        logic [MAX_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } aw_fields_t;

    // Requester index width; never below one bit so vectors stay legal.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/quark_idx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : quark_idx_fifo
//  Description : Synchronous FIFO of requester indices (W-order queue).
//  Revision    : 1.0 - initial release
// ============================================================================
module quark_idx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head    = mem[rd_ptr[PW-1:0]];
    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until pointed at.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/quark_egress_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : quark_egress_wr_arb
//  Description : Round-robin arbiter sharing the egress AXI write path among
//                NUM_REQ requesters; ID widened with requester index.
//  Revision    : 1.0 - initial release
// ============================================================================
module quark_egress_wr_arb
    import quark_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 512,
    parameter int WQ_DEPTH = 4,
    parameter int STRB_W   = DATA_W / 8,
    parameter int IDX_W    = idx_w(NUM_REQ),
    parameter int EID_W    = ID_W + IDX_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_awvalid,
    output logic [NUM_REQ-1:0]          req_awready,
    input  logic [NUM_REQ*ID_W-1:0]     req_awid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_awaddr,
    input  logic [NUM_REQ*8-1:0]        req_awlen,
    input  logic [NUM_REQ*3-1:0]        req_awsize,
    input  logic [NUM_REQ*2-1:0]        req_awburst,
    input  logic [NUM_REQ-1:0]          req_wvalid,
    output logic [NUM_REQ-1:0]          req_wready,
    input  logic [NUM_REQ-1:0]          req_wlast,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]          req_bvalid,
    input  logic [NUM_REQ-1:0]          req_bready,
    output logic [ID_W-1:0]             req_bid,
    output logic [1:0]                  req_bresp,
    output logic                        eg_awvalid,
    input  logic                        eg_awready,
    output logic [EID_W-1:0]            eg_awid,
    output logic [ADDR_W-1:0]           eg_awaddr,
    output logic [7:0]                  eg_awlen,
    output logic [2:0]                  eg_awsize,
    output logic [1:0]                  eg_awburst,
    output logic                        eg_wvalid,
    input  logic                        eg_wready,
    output logic [DATA_W-1:0]           eg_wdata,
    output logic [STRB_W-1:0]           eg_wstrb,
    output logic                        eg_wlast,
    input  logic                        eg_bvalid,
    output logic                        eg_bready,
    input  logic [EID_W-1:0]            eg_bid,
    input  logic [1:0]                  eg_bresp,
    output logic                        err_bad_bid
);

    // Returns {found, index}: first valid requester at or after ptr, with wrap.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        // Scan downward so the nearest hit overwrites farther ones.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (valid[idx[IDX_W-1:0]]) res = {1'b1, idx[IDX_W-1:0]};
        end
        return res;
    endfunction

    logic [IDX_W-1:0] rr_ptr;
    logic             found;
    logic [IDX_W-1:0] gnt_idx;
    logic             grant;
    logic             aw_free;
    aw_fields_t       aw_q;
    aw_fields_t       aw_next;
    logic             q_full;
    logic             q_empty;
    logic             q_pop;
    logic [IDX_W-1:0] q_head;
    logic [IDX_W-1:0] b_sel;
    logic             b_bad;
    logic             unused_aw;

    assign {found, gnt_idx} = rr_pick(req_awvalid, rr_ptr);
    assign aw_free = !eg_awvalid || eg_awready;
    assign grant   = rst_n && found && aw_free && (!q_full || q_pop);

    // One-hot AW ready pulse and selection of the winner's AW fields.
    always_comb begin
        req_awready = '0;
        aw_next     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                req_awready[i] = grant;
                aw_next.id     = MAX_EID_W'({gnt_idx, req_awid[i*ID_W +: ID_W]});
                aw_next.addr   = MAX_ADDR_W'(req_awaddr[i*ADDR_W +: ADDR_W]);
                aw_next.len    = req_awlen[i*8 +: 8];
                aw_next.size   = req_awsize[i*3 +: 3];
                aw_next.burst  = req_awburst[i*2 +: 2];
            end
        end
    end

    // AW output register: loads on grant, holds while stalled, clears on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eg_awvalid <= 1'b0;
            aw_q       <= '0;
        end else if (grant) begin
            eg_awvalid <= 1'b1;
            aw_q       <= aw_next;
        end else if (eg_awready) begin
            eg_awvalid <= 1'b0;
        end
    end

    assign eg_awid    = aw_q.id[EID_W-1:0];
    assign eg_awaddr  = aw_q.addr[ADDR_W-1:0];
    assign eg_awlen   = aw_q.len;
    assign eg_awsize  = aw_q.size;
    assign eg_awburst = aw_q.burst;
    assign unused_aw  = ^aw_q;

    // Round-robin pointer advances past each winner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    quark_idx_fifo #(
        .DEPTH (WQ_DEPTH),
        .W     (IDX_W)
    ) u_wq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant),
        .push_data (gnt_idx),
        .pop       (q_pop),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head)
    );

    // W path follows the queue head; only the head requester sees wready.
    always_comb begin
        eg_wvalid  = 1'b0;
        eg_wdata   = '0;
        eg_wstrb   = '0;
        eg_wlast   = 1'b0;
        req_wready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (q_head == IDX_W'(i)) begin
                eg_wvalid     = !q_empty && req_wvalid[i];
                eg_wdata      = req_wdata[i*DATA_W +: DATA_W];
                eg_wstrb      = req_wstrb[i*STRB_W +: STRB_W];
                eg_wlast      = req_wlast[i];
                req_wready[i] = eg_wready && !q_empty;
            end
        end
    end

    assign q_pop = eg_wvalid && eg_wready && eg_wlast;

    assign b_sel     = eg_bid[EID_W-1:ID_W];
    assign req_bid   = eg_bid[ID_W-1:0];
    assign req_bresp = eg_bresp;

    // Out-of-range indices exist only when NUM_REQ is not a power of two.
    if ((2 ** IDX_W) > NUM_REQ) begin : g_bad_chk
        assign b_bad = (int'(b_sel) >= NUM_REQ);
    end else begin : g_no_bad
        assign b_bad = 1'b0;
    end

    // B demux by the index bits; bad indices are swallowed.
    always_comb begin
        req_bvalid = '0;
        eg_bready  = 1'b0;
        if (rst_n) begin
            if (b_bad) begin
                eg_bready = 1'b1;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (b_sel == IDX_W'(i)) begin
                        req_bvalid[i] = eg_bvalid;
                        eg_bready     = req_bready[i];
                    end
                end
            end
        end
    end

    // Sticky error on any response carrying an out-of-range index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_bad_bid <= 1'b0;
        end else if (eg_bvalid && b_bad) begin
            err_bad_bid <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quark_egress_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quark_egress_wr_arb
//  Description : Directed self-checking bench for quark_egress_wr_arb
//                (three requesters so an out-of-range B index exists).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_quark_egress_wr_arb;

    localparam int NUM_REQ = 3;
    localparam int ID_W    = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int EID_W   = ID_W + 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_awvalid, req_awready;
    logic [NUM_REQ*ID_W-1:0]   req_awid;
    logic [NUM_REQ*ADDR_W-1:0] req_awaddr;
    logic [NUM_REQ*8-1:0]      req_awlen;
    logic [NUM_REQ*3-1:0]      req_awsize;
    logic [NUM_REQ*2-1:0]      req_awburst;
    logic [NUM_REQ-1:0]        req_wvalid, req_wready, req_wlast;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*STRB_W-1:0] req_wstrb;
    logic [NUM_REQ-1:0]        req_bvalid, req_bready;
    logic [ID_W-1:0]           req_bid;
    logic [1:0]                req_bresp;
    logic                      eg_awvalid, eg_awready;
    logic [EID_W-1:0]          eg_awid;
    logic [ADDR_W-1:0]         eg_awaddr;
    logic [7:0]                eg_awlen;
    logic [2:0]                eg_awsize;
    logic [1:0]                eg_awburst;
    logic                      eg_wvalid, eg_wready, eg_wlast;
    logic [DATA_W-1:0]         eg_wdata;
    logic [STRB_W-1:0]         eg_wstrb;
    logic                      eg_bvalid, eg_bready;
    logic [EID_W-1:0]          eg_bid;
    logic [1:0]                eg_bresp;
    logic                      err_bad_bid;

    int checks   = 0;
    int failures = 0;

    quark_egress_wr_arb #(
        .NUM_REQ  (NUM_REQ),
        .ID_W     (ID_W),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WQ_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_awvalid (req_awvalid),
        .req_awready (req_awready),
        .req_awid    (req_awid),
        .req_awaddr  (req_awaddr),
        .req_awlen   (req_awlen),
        .req_awsize  (req_awsize),
        .req_awburst (req_awburst),
        .req_wvalid  (req_wvalid),
        .req_wready  (req_wready),
        .req_wlast   (req_wlast),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .req_bvalid  (req_bvalid),
        .req_bready  (req_bready),
        .req_bid     (req_bid),
        .req_bresp   (req_bresp),
        .eg_awvalid  (eg_awvalid),
        .eg_awready  (eg_awready),
        .eg_awid     (eg_awid),
        .eg_awaddr   (eg_awaddr),
        .eg_awlen    (eg_awlen),
        .eg_awsize   (eg_awsize),
        .eg_awburst  (eg_awburst),
        .eg_wvalid   (eg_wvalid),
        .eg_wready   (eg_wready),
        .eg_wdata    (eg_wdata),
        .eg_wstrb    (eg_wstrb),
        .eg_wlast    (eg_wlast),
        .eg_bvalid   (eg_bvalid),
        .eg_bready   (eg_bready),
        .eg_bid      (eg_bid),
        .eg_bresp    (eg_bresp),
        .err_bad_bid (err_bad_bid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_awvalid = 3'b011; req_awid = '0; req_awaddr = '0; req_awlen = '0;
        req_awsize = '0; req_awburst = '0;
        req_wvalid = 3'b111; req_wlast = '0; req_wdata = '0; req_wstrb = '1;
        req_bready = 3'b111;
        eg_awready = 1'b0; eg_wready = 1'b1;
        eg_bvalid = 1'b1; eg_bid = '0; eg_bresp = 2'b00;

        // ---------------- reset state ----------------
        step(); step();
        chk("rst_awvalid", eg_awvalid, 1'b0);
        chk("rst_awid", eg_awid, 6'h00);
        chk("rst_awready", req_awready, 3'b000);
        chk("rst_wvalid", eg_wvalid, 1'b0);
        chk("rst_wready", req_wready, 3'b000);
        chk("rst_bvalid", req_bvalid, 3'b000);
        chk("rst_bready", eg_bready, 1'b0);
        chk("rst_err", err_bad_bid, 1'b0);

        // ---------------- single write from requester 1 ----------------
        rst_n = 1'b1;
        req_wvalid = '0; req_bready = '0; eg_bvalid = 1'b0;
        req_awvalid = 3'b010;
        req_awid[7:4] = 4'd3; req_awaddr[63:32] = 32'h0000_1000;
        req_awlen[15:8] = 8'd3; req_awsize[5:3] = 3'd2; req_awburst[3:2] = 2'd1;
        eg_awready = 1'b1; eg_wready = 1'b0;
        #1;
        chk("sw_awready", req_awready, 3'b010);
        step();
        req_awvalid = '0;
        chk("sw_eg_awvalid", eg_awvalid, 1'b1);
        chk("sw_eg_awid", eg_awid, 6'h13);
        chk("sw_eg_awaddr", eg_awaddr, 32'h0000_1000);
        chk("sw_eg_awlen", eg_awlen, 8'd3);
        chk("sw_eg_awburst", eg_awburst, 2'd1);
        req_wvalid = 3'b011; eg_wready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            req_wdata[63:32] = 32'hA0 + b;
            req_wlast = (b == 3) ? 3'b010 : 3'b000;
            #1;
            chk("sw_wready", req_wready, 3'b010);
            chk("sw_wvalid", eg_wvalid, 1'b1);
            chk("sw_wdata", eg_wdata, 32'hA0 + b);
            chk("sw_wlast", eg_wlast, (b == 3));
            step();
        end
        chk("sw_aw_accepted", eg_awvalid, 1'b0);
        chk("sw_q_empty_wvalid", eg_wvalid, 1'b0);
        chk("sw_q_empty_wready", req_wready, 3'b000);
        req_wvalid = '0; req_wlast = '0;
        eg_bvalid = 1'b1; eg_bid = 6'h13; eg_bresp = 2'b10; req_bready = 3'b010;
        #1;
        chk("sw_bvalid", req_bvalid, 3'b010);
        chk("sw_bid", req_bid, 4'd3);
        chk("sw_bresp", req_bresp, 2'b10);
        chk("sw_eg_bready", eg_bready, 1'b1);
        req_bready = 3'b101;
        #1;
        chk("sw_eg_bready_low", eg_bready, 1'b0);
        eg_bvalid = 1'b0; req_bready = '0;
        step();

        // ---------------- round robin, then queue full ----------------
        eg_wready = 1'b0;
        req_awid[3:0] = 4'd5; req_awid[7:4] = 4'd6;
        req_awvalid = 3'b011;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_awready", req_awready, (k % 2 == 0) ? 3'b001 : 3'b010);
            step();
            chk("rr_eg_awid", eg_awid, (k % 2 == 0) ? 6'h05 : 6'h16);
        end
        chk("qf_blocked0", req_awready, 3'b000);
        step();
        chk("qf_blocked1", req_awready, 3'b000);
        req_wvalid = 3'b001; req_wlast = 3'b001; eg_wready = 1'b1;
        #1;
        chk("qf_pop_wready", req_wready, 3'b001);
        chk("qf_grant_on_pop", req_awready, 3'b001);
        step();
        req_awvalid = '0;
        chk("qf_eg_awid", eg_awid, 6'h05);
        chk("qf_eg_awvalid", eg_awvalid, 1'b1);

        // ---------------- W ordering: head is requester 1 ----------------
        req_wdata[31:0] = 32'h1111_1111; req_wdata[63:32] = 32'h2222_2222;
        #1;
        chk("wo_r0_blocked_wvalid", eg_wvalid, 1'b0);
        chk("wo_r0_blocked_wready", req_wready, 3'b010);
        step();
        chk("wo_r0_still_blocked", req_wready, 3'b010);
        req_wvalid = 3'b011; req_wlast = 3'b011;
        #1;
        chk("wo_r1_wdata", eg_wdata, 32'h2222_2222);
        chk("wo_r1_wready", req_wready, 3'b010);
        step();
        chk("wo_r0_now_ready", req_wready, 3'b001);
        chk("wo_r0_wdata", eg_wdata, 32'h1111_1111);
        step(); step(); step();
        chk("wo_drained", eg_wvalid, 1'b0);
        req_wvalid = '0; req_wlast = '0; eg_wready = 1'b0;

        // ---------------- AW backpressure ----------------
        eg_awready = 1'b0;
        req_awvalid = 3'b100; req_awid[11:8] = 4'd9; req_awaddr[95:64] = 32'h0000_2000;
        #1;
        chk("bp_grant2", req_awready, 3'b100);
        step();
        req_awvalid = 3'b011;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_no_awready", req_awready, 3'b000);
            chk("bp_awid_stable", eg_awid, 6'h29);
            chk("bp_awaddr_stable", eg_awaddr, 32'h0000_2000);
            chk("bp_awvalid", eg_awvalid, 1'b1);
            step();
        end
        eg_awready = 1'b1;
        #1;
        chk("bp_release_grant", req_awready, 3'b001);
        step();
        req_awvalid = '0;
        chk("bp_next_awid", eg_awid, 6'h05);

        // ---------------- bad B index ----------------
        chk("bb_err_before", err_bad_bid, 1'b0);
        eg_bvalid = 1'b1; eg_bid = 6'h30; req_bready = '0;
        #1;
        chk("bb_bready", eg_bready, 1'b1);
        chk("bb_no_bvalid", req_bvalid, 3'b000);
        step();
        eg_bvalid = 1'b0; eg_bid = '0;
        chk("bb_err_set", err_bad_bid, 1'b1);
        step();
        chk("bb_err_sticky", err_bad_bid, 1'b1);

        // drain queue (heads 2 then 0)
        req_wvalid = 3'b101; req_wlast = 3'b101; eg_wready = 1'b1;
        step(); step();
        chk("dr_empty", eg_wvalid, 1'b0);
        req_wvalid = '0; req_wlast = '0;

        // ---------------- reset mid-burst ----------------
        req_awvalid = 3'b010; req_awid[7:4] = 4'd3; req_awlen[15:8] = 8'd3;
        #1;
        chk("rm_grant1", req_awready, 3'b010);
        step();
        req_awvalid = '0; req_wvalid = 3'b010; req_wlast = '0;
        #1;
        chk("rm_beat_wready", req_wready, 3'b010);
        step(); step();
        rst_n = 1'b0; req_awvalid = 3'b111;
        #1;
        chk("rm_in_reset_awready", req_awready, 3'b000);
        step();
        rst_n = 1'b1;
        #1;
        chk("rm_awvalid", eg_awvalid, 1'b0);
        chk("rm_awid", eg_awid, 6'h00);
        chk("rm_wvalid", eg_wvalid, 1'b0);
        chk("rm_wready", req_wready, 3'b000);
        chk("rm_err", err_bad_bid, 1'b0);
        chk("rm_next_grant0", req_awready, 3'b001);
        step();
        req_awvalid = '0;
        chk("rm_next_awid", eg_awid, 6'h05);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
